// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared types and constants for the voice scheduler
package voice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_APPLY  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int TARGET_W = 16;
    localparam int NOTE_W   = 7;
    localparam int FS_MSB   = 15;
    localparam int STEP_W   = 3;

    function automatic int rank_w(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// rtl/voice_age_tracker.sv - per-voice age ranks (0 = newest), kept as a permutation
module voice_age_tracker #(
    parameter int NUM_VOICES = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     touch,
    input  logic [$clog2(NUM_VOICES)-1:0]            touch_idx,
    output logic [$clog2(NUM_VOICES)-1:0]            oldest_idx,
    output logic [NUM_VOICES*$clog2(NUM_VOICES)-1:0] ranks
);
    localparam int RW = $clog2(NUM_VOICES);

    logic [RW-1:0] rank [NUM_VOICES];
    logic [RW-1:0] touched_rank;

    assign touched_rank = rank[touch_idx];

    // Touched voice becomes newest; only voices younger than it age by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) rank[v] <= RW'(v);
        end else if (touch) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (RW'(v) == touch_idx)
                    rank[v] <= '0;
                else if (rank[v] < touched_rank)
                    rank[v] <= rank[v] + 1'b1;
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        ranks      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (rank[v] == RW'(NUM_VOICES - 1)) oldest_idx = RW'(v);
            ranks[v*RW +: RW] = rank[v];
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - note-on/off voice allocator; VOICE_STEAL_EN enables stealing the oldest held voice
module voice_scheduler
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int RETRIG_GAP = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_on,
    input  logic [NOTE_W-1:0]              cmd_note,
    input  logic [TARGET_W-1:0]            cmd_target,
    input  logic [NUM_VOICES-1:0]          voice_running,
    output logic [NUM_VOICES-1:0]          voice_gate,
    output logic [TARGET_W*NUM_VOICES-1:0] voice_target,
    output logic                           dropped
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(RETRIG_GAP + 1);
`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    state_t                state, state_nxt;
    logic                  ready_q;
    logic                  on_q;
    logic [NOTE_W-1:0]     note_q;
    logic [TARGET_W-1:0]   tgt_q;
    logic [NUM_VOICES-1:0] gate;
    logic [TARGET_W-1:0]   target [NUM_VOICES];
    logic [NOTE_W-1:0]     note   [NUM_VOICES];
    logic                  hit_f, free_f, rel_f;
    logic [IW-1:0]         hit_i, free_i, rel_i, old_i;
    logic                  s_hit_f, s_free_f, s_rel_f;
    logic [IW-1:0]         s_hit_i, s_free_i, s_rel_i, s_best;
    logic [IW-1:0]         sel, gap_sel, oldest_idx;
    logic [CW-1:0]         gap_cnt;
    logic                  can_alloc, do_gap, touch;
    logic [NUM_VOICES*IW-1:0] ranks;

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch      (touch),
        .touch_idx  (sel),
        .oldest_idx (oldest_idx),
        .ranks      (ranks)
    );

    // Lowest-index hit/free found by scanning downward; rel keeps the oldest rank.
    always_comb begin
        s_hit_f = 1'b0; s_hit_i = '0;
        s_free_f = 1'b0; s_free_i = '0;
        s_rel_f = 1'b0; s_rel_i = '0; s_best = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate[v] && note[v] == note_q) begin s_hit_f = 1'b1; s_hit_i = IW'(v); end
            if (!gate[v] && !voice_running[v]) begin s_free_f = 1'b1; s_free_i = IW'(v); end
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!gate[v] && voice_running[v] && (!s_rel_f || ranks[v*IW +: IW] > s_best)) begin
                s_rel_f = 1'b1;
                s_rel_i = IW'(v);
                s_best  = ranks[v*IW +: IW];
            end
        end
    end

    always_comb begin
        sel = old_i;
        if (rel_f)  sel = rel_i;
        if (free_f) sel = free_i;
        if (hit_f)  sel = hit_i;
        can_alloc = hit_f || free_f || rel_f || STEAL_EN;
        do_gap    = hit_f || !(free_f || rel_f);
        touch     = (state == ST_APPLY) && on_q && can_alloc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cmd_valid && cmd_ready) state_nxt = ST_SEARCH;
            ST_SEARCH: state_nxt = ST_APPLY;
            ST_APPLY:  state_nxt = (on_q && can_alloc && do_gap) ? ST_GAP : ST_IDLE;
            ST_GAP:    if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = ready_q && (state == ST_IDLE);
        dropped   = (state == ST_APPLY) && on_q && !can_alloc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            on_q    <= 1'b0;
            note_q  <= '0;
            tgt_q   <= '0;
            gate    <= '0;
            hit_f   <= 1'b0; free_f <= 1'b0; rel_f <= 1'b0;
            hit_i   <= '0;   free_i <= '0;   rel_i <= '0; old_i <= '0;
            gap_sel <= '0;
            gap_cnt <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                target[v] <= '0;
                note[v]   <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (state == ST_IDLE && cmd_valid && cmd_ready) begin
                on_q   <= cmd_on;
                note_q <= cmd_note;
                tgt_q  <= cmd_target;
            end
            if (state == ST_SEARCH) begin
                hit_f <= s_hit_f;  hit_i  <= s_hit_i;
                free_f <= s_free_f; free_i <= s_free_i;
                rel_f <= s_rel_f;  rel_i  <= s_rel_i;
                old_i <= oldest_idx;
            end
            if (state == ST_APPLY) begin
                if (!on_q) begin
                    if (hit_f) gate[hit_i] <= 1'b0;
                end else if (can_alloc) begin
                    target[sel] <= tgt_q;
                    note[sel]   <= note_q;
                    gate[sel]   <= !do_gap;
                    gap_sel     <= sel;
                    gap_cnt     <= CW'(RETRIG_GAP - 1);
                end
            end
            if (state == ST_GAP) begin
                if (gap_cnt == '0) gate[gap_sel] <= 1'b1;
                else               gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign voice_gate = gate;
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_tgt
        assign voice_target[v*TARGET_W +: TARGET_W] = target[v];
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - scoreboard bench for voice_scheduler (honours VOICE_STEAL_EN)
module tb_voice_scheduler;
    localparam int NV  = 4;
    localparam int GAP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_on = 1'b0;
    logic [6:0]    cmd_note = '0;
    logic [15:0]   cmd_target = '0;
    logic [NV-1:0] voice_running = '0;
    logic [NV-1:0] voice_gate;
    logic [63:0]   voice_target;
    logic          dropped;

    voice_scheduler #(.NUM_VOICES(NV), .RETRIG_GAP(GAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_on        (cmd_on),
        .cmd_note      (cmd_note),
        .cmd_target    (cmd_target),
        .voice_running (voice_running),
        .voice_gate    (voice_gate),
        .voice_target  (voice_target),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [3:0]  gate;
        logic [63:0] tgt;
        logic        drop;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  m_gate;
    logic [63:0] m_tgt;
    int          m_note[NV];
    int          order[$];
    bit          mon_en = 1'b0;
    logic [3:0]  prev_gate = '0;
    logic [63:0] prev_tgt = '0;

    always @(negedge clk) begin
        if (mon_en && (voice_gate !== prev_gate || voice_target !== prev_tgt || dropped === 1'b1)) begin
            if (sb.size() == 0) begin
                check("event_expected", sb.size(), 1);
            end else begin
                check("evt_cycle", cyc, sb[0].cyc);
                check("evt_gate", voice_gate, sb[0].gate);
                check("evt_target", voice_target, sb[0].tgt);
                check("evt_dropped", dropped, sb[0].drop);
                void'(sb.pop_front());
            end
        end
        prev_gate <= voice_gate;
        prev_tgt  <= voice_target;
    end

    task automatic model_reset();
        m_gate = '0;
        m_tgt  = '0;
        order  = {};
        for (int i = 0; i < NV; i++) begin
            order.push_back(i);
            m_note[i] = -1;
        end
    endtask

    task automatic push(input int c, input logic d);
        exp_t e;
        e.cyc = c; e.gate = m_gate; e.tgt = m_tgt; e.drop = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_gate", voice_gate, 0);
        check("rst_target", voice_target, 0);
        check("rst_dropped", dropped, 0);
        check("rst_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        model_reset();
        #1 check("ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);
        mon_en = 1'b1;
    endtask

    task automatic send(input bit on, input int note, input logic [15:0] tgt);
        int a, k, hit, free, rel, sel;
        bit gap, drop;
        @(negedge clk);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            check("ready_timeout", cmd_ready, 1);
            return;
        end
        cmd_valid = 1'b1; cmd_on = on; cmd_note = 7'(note); cmd_target = tgt;
        @(posedge clk);
        #1;
        a = cyc;
        cmd_valid = 1'b0; cmd_on = 1'($urandom); cmd_note = 7'($urandom); cmd_target = 16'($urandom);

        hit = -1; free = -1; rel = -1; sel = -1; gap = 0; drop = 0;
        for (int v = NV - 1; v >= 0; v--) begin
            if (m_gate[v] && m_note[v] == note) hit = v;
            if (!m_gate[v] && !voice_running[v]) free = v;
        end
        for (int i = order.size() - 1; i >= 0; i--)
            if (rel < 0 && !m_gate[order[i]] && voice_running[order[i]]) rel = order[i];

        if (!on) begin
            if (hit >= 0) begin
                m_gate[hit] = 1'b0;
                push(a + 2, 1'b0);
            end
        end else begin
            if (hit >= 0)       begin sel = hit; gap = 1; end
            else if (free >= 0) sel = free;
            else if (rel >= 0)  sel = rel;
            else begin
`ifdef VOICE_STEAL_EN
                sel = order[NV-1]; gap = 1;
`else
                drop = 1;
`endif
            end
            if (drop) begin
                push(a + 1, 1'b1);
            end else begin
                m_tgt[sel*16 +: 16] = tgt;
                m_note[sel] = note;
                for (int i = 0; i < order.size(); i++)
                    if (order[i] == sel) begin order.delete(i); break; end
                order.push_front(sel);
                if (gap) begin
                    m_gate[sel] = 1'b0;
                    push(a + 2, 1'b0);
                    m_gate[sel] = 1'b1;
                    push(a + 2 + GAP, 1'b0);
                end else begin
                    m_gate[sel] = 1'b1;
                    push(a + 2, 1'b0);
                end
            end
        end
        @(negedge clk) check("ready_search", cmd_ready, 0);
        @(negedge clk) check("ready_apply", cmd_ready, 0);
        @(negedge clk) check("ready_after_apply", cmd_ready, gap ? 0 : 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        send(1, 60, 16'h3E80);
        check("first_gate", voice_gate, 4'b0001);
        check("first_target", voice_target[15:0], 16'h3E80);
        send(1, 62, 16'h4100);
        send(1, 64, 16'h4900);
        send(1, 65, 16'h4D08);
        voice_running = 4'b1111;
        send(1, 67, 16'h5700);
        drain();
        send(0, 62, 16'h0000);
        send(1, 70, 16'h6200);
        send(1, 70, 16'h6208);
        send(0, 99, 16'h0000);
        send(0, 64, 16'h0000);
        send(0, 65, 16'h0000);
        voice_running = 4'b1011;
        send(1, 72, 16'h7000);
        send(1, 74, 16'h7400);
        drain();

        do_reset();
        voice_running = '0;
        send(1, 60, 16'h3E80);
        send(1, 60, 16'h3E88);
        send(0, 99, 16'h0000);
        drain();
        check("retrig_gates", voice_gate, 4'b0001);

        send(1, 60, 16'h1111);
        repeat (3) @(negedge clk);
        #2;
        do_reset();
        send(1, 5, 16'h0505);
        drain();
        check("post_reset_gate", voice_gate, 4'b0001);
        check("post_reset_target", voice_target, 64'h0505);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Allocates incoming note-on/note-off commands (decoded from the SPI command path) across NUM_VOICES synth voices.
- Each voice is a wavetable oscillator plus envelope pair. The block drives each voice's gate (ADSR START / wavetable enable) and its packed pitch target word (Fs[15:3], step[2:0], the portamento target format).
- Allocation order: free voice first, then the oldest released voice, then the oldest held voice (steal).

Parameters:
- NUM_VOICES, 4, number of voices scheduled (2..8).
- RETRIG_GAP, 8, clk cycles the gate is held low before re-asserting on retrigger/steal (must be ≥4 so the 3-stage edge detectors in the voices see the falling edge).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_on  in  1  1 = note-on, 0 = note-off
- cmd_note  in  7  note number
- cmd_target  in  16  packed {Fs[12:0], step[2:0]} for note-on
- voice_running  in  NUM_VOICES  per-voice envelope RUNNING
- voice_gate  out  NUM_VOICES  per-voice gate
- voice_target  out  16*NUM_VOICES  per-voice target word; voice v at bits [16v+15:16v]
- dropped  out  1  one-cycle pulse when a note-on is discarded

Behaviour:
- Reset (async assert, sync release):
  - voice_gate=0, voice_target=0, dropped=0, cmd_ready=0.
  - All notes cleared; age rank[v]=v; FSM enters IDLE.
  - cmd_ready rises on the first clk edge after release.
- FSM states: IDLE, SEARCH, APPLY, GAP.
- IDLE:
  - cmd_ready=1. Accept when cmd_valid && cmd_ready: latch cmd_on/cmd_note/cmd_target and go to SEARCH.
  - cmd_ready=0 in every other state.
- SEARCH (1 cycle): registers these results:
  - hit = lowest v with gate[v]=1 && note[v]==cmd_note
  - free = lowest v with gate=0 && running=0
  - rel = the v with gate=0 && running=1 having the highest rank
  - old = the v with rank==NUM_VOICES-1
- APPLY, note-off:
  - With hit: gate[hit]<=0.
  - No hit: no change; silently ignored.
  - Go to IDLE.
- APPLY, note-on:
  - Selection priority: hit (retrigger) > free > rel > old (steal).
  - Write target[sel] and note[sel]; update ranks: rank[sel]<=0, and every voice whose rank < old rank[sel] increments.
  - If sel is free or rel: gate[sel]<=1, go to IDLE.
  - If retrigger or steal: gate[sel]<=0, load gap counter with RETRIG_GAP-1, go to GAP.
- GAP: counter decrements each cycle. At 0: gate[sel]<=1, go to IDLE.
- Latency:
  - voice_gate/voice_target change on the 2nd clk edge after the accept edge.
  - Retrigger/steal re-gates RETRIG_GAP cycles after that.
- Throughput: one command per 3 cycles (free/off), or 3+RETRIG_GAP cycles (retrigger/steal).
- Ranks always form a permutation of 0..NUM_VOICES-1. A note-off never changes ranks.
- voice_target holds its value after gate drops, so the release tail keeps its pitch.
- A duplicate note-on while held is a retrigger; no second voice is allocated.
- cmd_valid dropped before acceptance: no effect. Command fields are ignored outside the accept cycle.
- Reset mid-GAP: immediate return to the reset state; the pending gate re-assert is lost.

Optional Feature:
- VOICE_STEAL_EN defined: behaviour as above.
- VOICE_STEAL_EN undefined:
  - A note-on with no hit, free or rel voice is discarded; dropped pulses 1 cycle in APPLY.
  - No gate, target or rank change; FSM returns to IDLE.
  - Retrigger of a held note is unaffected.

Decomposition:
- Package voice_pkg: FSM state encoding (2-bit), TARGET_W=16, NOTE_W=7, rank width $clog2(NUM_VOICES), target field slicing constants (FS_MSB=15, STEP_W=3).
- Sub-module voice_age_tracker: holds ranks; inputs touch, touch_idx; outputs oldest_idx and the per-voice rank vector.

Test Plan:
- Reset, then note-on 60/0x3E80 → gate=0001 and target[0]=0x3E80 on the 2nd edge after accept; cmd_ready low for 2 cycles.
- Note-on 60,62,64,65 then 67 with all running=1 and all gated → voice 0 (oldest) gate low for exactly 8 cycles, then high with target[0]=67's word.
- Same as above with VOICE_STEAL_EN undefined → dropped=1 for 1 cycle; gates stay 1111; targets unchanged.
- Note-off 62 → gate[1]=0. Then note-on 70 with running[1]=1, others gated → voice 1 reused with no gap.
- Note-on 60 twice → second command retriggers voice 0 (gap of 8 cycles); gate[1..3] stay 0. Note-off 99 → no output change.
- Assert rst_n low during GAP → gates, targets and dropped go 0 immediately (asynchronous); next command after release is allocated to voice 0.
